// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: drives a req/ack data-memory port, stalls while an access is
// outstanding, resolves branch/jump redirects and loads the MEM/WB register.
module mem_access_stage #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Ctl_MemtoReg_in,
  input  logic        Ctl_RegWrite_in,
  input  logic        Ctl_MemRead_in,
  input  logic        Ctl_MemWrite_in,
  input  logic        Ctl_Branch_in,
  input  logic        Zero_in,
  input  logic        jal_in,
  input  logic        jalr_in,
  input  logic [4:0]  Rd_in,
  input  logic [31:0] ALUresult_in,
  input  logic [31:0] PCimm_in,
  input  logic [31:0] ReadData2_in,
  input  logic [31:0] PC_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_out,
  output logic        pc_redirect,
  output logic [31:0] branch_target,
  output logic [31:0] mem_data,
  output logic        bus_err,
  output logic        Ctl_MemtoReg_out,
  output logic        Ctl_RegWrite_out,
  output logic [4:0]  Rd_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUresult_out
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       bus_err_nxt;
  logic       mem_op, link, timeout, done;

  // Return address for jal/jalr; wraps modulo 2^32.
  function automatic logic [31:0] link_addr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  assign mem_op    = Ctl_MemRead_in | Ctl_MemWrite_in;
  assign link      = jal_in | jalr_in;
  assign timeout   = (state == BUSY) & ~dmem_ack & (wait_cnt == MAX_CNT);
  assign done      = mem_op & (dmem_ack | timeout);
  assign stall_out = mem_op & ~done & ~reset;

  // ---- access FSM: state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      bus_err  <= bus_err_nxt;
    end
  end

  // ---- access FSM: next state ----
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    bus_err_nxt  = bus_err;
    case (state)
      IDLE: begin
        // A late ack with no access pending is simply ignored here.
        if (mem_op && !dmem_ack) begin
          state_nxt    = BUSY;
          wait_cnt_nxt = 8'd1;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == MAX_CNT) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = 8'd0;
          bus_err_nxt  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // ---- access FSM: outputs and redirect ----
  // Address/data come straight from EX/MEM, which the stall holds stable while BUSY.
  always_comb begin
    dmem_req      = ~reset & mem_op;
    dmem_we       = Ctl_MemWrite_in;
    dmem_addr     = ALUresult_in;
    dmem_wdata    = ReadData2_in;
    mem_data      = link ? link_addr(PC_in) : ALUresult_in;
    pc_redirect   = ~reset & ((Ctl_Branch_in & Zero_in) | link);
    branch_target = jalr_in ? {ALUresult_in[31:1], 1'b0} : PCimm_in;
  end

  // ---- MEM/WB register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      Ctl_MemtoReg_out <= 1'b0;
      Ctl_RegWrite_out <= 1'b0;
      Rd_out           <= 5'd0;
      ReadData_out     <= 32'd0;
      ALUresult_out    <= 32'd0;
    end else if (stall_out) begin
      Ctl_MemtoReg_out <= 1'b0;
      Ctl_RegWrite_out <= 1'b0;
    end else begin
      Ctl_MemtoReg_out <= Ctl_MemtoReg_in;
      Ctl_RegWrite_out <= Ctl_RegWrite_in;
      Rd_out           <= Rd_in;
      ReadData_out     <= (Ctl_MemRead_in && dmem_ack && !timeout) ? dmem_rdata : 32'd0;
      ALUresult_out    <= link ? link_addr(PC_in) : ALUresult_in;
    end
  end

endmodule
